// File: rtl/tick_timer_sched_pkg.sv
// Shared types and constants for the tick-driven timer scheduler.
package tick_timer_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  localparam logic CMD_ARM    = 1'b0;
  localparam logic CMD_CANCEL = 1'b1;

  // Ceiling log2, used to size channel indices.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/tick_timer_bank.sv
// Counter storage for all channels plus the single shared decrementer.
// One channel is read/written per cycle, selected by idx_i.
module tick_timer_bank
  import tick_timer_sched_pkg::*;
#(
  parameter int  NCH = 4,
  parameter int  TW  = 16,
  localparam int CW  = clog2(NCH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] idx_i,
  input  logic          we_i,
  input  logic          dec_i,     // 1: write back count-1, 0: write ld_val_i
  input  logic [TW-1:0] ld_val_i,
  output logic          zero_o     // decremented count of idx_i is zero
);

  logic [NCH-1:0][TW-1:0] cnt_q;
  logic [TW-1:0]          rd_cnt;
  logic [TW-1:0]          dec_cnt;

  assign rd_cnt  = cnt_q[idx_i];
  assign dec_cnt = rd_cnt - TW'(1);
  assign zero_o  = (dec_cnt == '0);

  // Counter storage: load from the command port or write back the decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (we_i) begin
      cnt_q[idx_i] <= dec_i ? dec_cnt : ld_val_i;
    end
  end

endmodule

// File: rtl/tick_timer_sched.sv
// Multi-channel software timer scheduler. Each tick starts a sweep that
// services one channel per cycle through a shared decrementer. Commands are
// only taken while idle, so the sweep never collides with a command write.
module tick_timer_sched
  import tick_timer_sched_pkg::*;
#(
  parameter int  NCH = 4,
  parameter int  TW  = 16,
  localparam int CW  = clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_cancel,
  input  logic [CW-1:0]  cmd_ch,
  input  logic [TW-1:0]  cmd_count,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] expire,
  output logic           overrun,
  input  logic           ovr_clr
);

  state_e         state_q, state_d;
  logic [CW-1:0]  idx_q, idx_d;
  logic [NCH-1:0] busy_q, busy_d;
  logic [NCH-1:0] expire_q, expire_d;
  logic           overrun_q, overrun_d;

  logic [CW-1:0]  bank_idx;
  logic           bank_we;
  logic           bank_dec;
  logic [TW-1:0]  bank_ld;
  logic           bank_zero;
  logic           accept;

  assign accept = cmd_valid && (state_q == IDLE);

  tick_timer_bank #(.NCH(NCH), .TW(TW)) u_bank (
    .clk      (clk),
    .rst      (rst),
    .idx_i    (bank_idx),
    .we_i     (bank_we),
    .dec_i    (bank_dec),
    .ld_val_i (bank_ld),
    .zero_o   (bank_zero)
  );

  // State and per-channel flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      busy_q    <= '0;
      expire_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      expire_q  <= expire_d;
      overrun_q <= overrun_d;
    end
  end

  // Next state, bank control and busy/expire updates. A command taken in the
  // tick cycle writes first; the sweep then sees the freshly armed value.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    expire_d = '0;
    bank_idx = cmd_ch;
    bank_we  = 1'b0;
    bank_dec = 1'b0;
    bank_ld  = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          bank_we = 1'b1;
          if (cmd_cancel == CMD_CANCEL) begin
            busy_d[cmd_ch] = 1'b0;
          end else begin
            // A zero-count arm never runs; it just reports expiry once.
            bank_ld          = cmd_count;
            busy_d[cmd_ch]   = (cmd_count != '0);
            expire_d[cmd_ch] = (cmd_count == '0);
          end
        end
        if (tick) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        bank_idx = idx_q;
        bank_dec = 1'b1;
        bank_we  = busy_q[idx_q];
        if (busy_q[idx_q] && bank_zero) begin
          busy_d[idx_q]   = 1'b0;
          expire_d[idx_q] = 1'b1;
        end
        if (idx_q == CW'(NCH - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky overrun: a tick landing mid-sweep is dropped; set beats clear.
  always_comb begin
    overrun_d = overrun_q;
    if (tick && (state_q == SWEEP)) overrun_d = 1'b1;
    else if (ovr_clr)               overrun_d = 1'b0;
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = busy_q;
  assign expire    = expire_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/tick_timer_sched.md
Name: tick_timer_sched

Overview:
- Multi-channel software-timer scheduler driven by the one-cycle tick pulse from the team's clock divider.
- Holds NCH independent countdown timers that share one decrementer. On each tick, a sweep FSM services the channels one per clk cycle.
- Firmware and control logic arm or cancel timers through a valid/ready port and receive one-cycle expire pulses per channel.

Parameters:
- NCH, 4, number of timer channels (>=2).
- TW, 16, timer count width in ticks.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- tick  in  1  one-cycle tick pulse from the clock divider, synchronous to clk
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- cmd_cancel  in  1  1 = cancel channel, 0 = arm channel
- cmd_ch  in  clog2(NCH)  target channel
- cmd_count  in  TW  arm value in ticks (ignored for cancel)
- busy  out  NCH  per-channel active flag
- expire  out  NCH  per-channel one-cycle expiry pulse
- overrun  out  1  sticky: a tick arrived while a sweep was in progress
- ovr_clr  in  1  clears overrun

Behaviour:
- Reset (async, rst=1): FSM in IDLE; all counters 0; busy=0; expire=0; overrun=0; sweep index 0.
- FSM states:
  - IDLE -> SWEEP on tick.
  - SWEEP visits channels 0..NCH-1, one per cycle, then returns to IDLE.
  - A sweep occupies exactly NCH cycles.
- Timing for a tick at cycle T, FSM in IDLE:
  - Channel i is processed at cycle T+1+i.
  - FSM is back in IDLE at T+NCH+1.
- cmd_ready: registered-state decode, high iff FSM is in IDLE (this includes the tick cycle T). Low throughout SWEEP. cmd_valid may be held; the command is taken on the first IDLE cycle.
- Arm, count N>0: counter[ch]=N and busy[ch]=1 from the next cycle. Arming a busy channel restarts it with N, with no expire for the old run.
- Arm, count 0: busy stays 0; expire[ch] pulses exactly once in the cycle after acceptance.
- Cancel: busy[ch]=0, counter cleared, no expire. Cancelling an idle channel is a no-op.
- Command accepted in the same cycle as tick: the write lands before the sweep, so the armed value is decremented by that tick.
- Sweep processing: for channel i, if busy[i], counter[i] decrements by 1 (shared TW-bit decrementer, no wrap since busy implies count>=1).
- Expiry: if a sweep takes counter[i] 1->0, then busy[i] clears and expire[i] pulses for one cycle at T+2+i. A timer armed with N therefore expires on the N-th tick after arming.
- Multiple channels expiring in one sweep produce pulses in consecutive cycles, never simultaneously, except for a count-0 arm pulse.
- Tick during SWEEP: the tick is dropped and overrun is set (sticky). No channel is decremented twice. Integrators must choose a divider ratio > NCH+1.
- Overrun clear: ovr_clr=1 clears overrun. Simultaneous tick-in-SWEEP and ovr_clr leaves overrun=1 (set wins).
- rst mid-sweep: all state returns to reset values immediately. No expire pulses are emitted after reset.

Decomposition:
- Shared package: FSM state enum (IDLE, SWEEP), command encoding constants (CMD_ARM=0, CMD_CANCEL=1), helper clog2 function.
- One natural sub-module, tick_timer_bank: counter storage plus the shared decrementer. Interface: read/write index, write enable, load value, zero flag. The top level keeps the FSM, the command handshake, busy/expire and overrun.

Test Plan:
All scenarios use NCH=4, TW=8; ticks are spaced 10 cycles apart unless stated.
1. Reset check: rst pulse -> busy=0000, expire=0000, overrun=0, cmd_ready=1 once rst is released.
2. Single arm then ticks:
   - Stimulus: arm ch2 count 3, then 3 ticks.
   - Required: busy[2]=1 after acceptance; expire[2] pulses once, at T3+4 where T3 is the third tick cycle; busy[2]=0 afterwards.
3. Concurrent expiry:
   - Stimulus: arm ch0=1, ch1=1, ch3=1, then 1 tick at cycle T.
   - Required: expire[0] at T+2, expire[1] at T+3, expire[3] at T+5; never two pulses in the same cycle.
4. Handshake, restart and cancel:
   - cmd_valid held during a sweep -> cmd_ready=0 for 4 cycles, then the command is accepted.
   - Re-arm of busy ch1 with 5 -> no expire until 5 further ticks.
   - Cancel ch1 -> busy[1]=0 and no expire.
5. Count-0 arm and same-cycle tick:
   - Arm ch3 count 0 -> expire[3] on the next cycle, busy[3] never 1.
   - Arm ch0 count 1 in the same cycle as tick at T -> expire[0] at T+2.
6. Overrun and reset mid-sweep:
   - Tick spacing 3 cycles -> overrun=1 and the dropped tick does not decrement any channel.
   - ovr_clr -> overrun=0.
   - rst asserted at T+2 of a sweep -> all outputs 0 and no later expire pulses.
